// File: rtl/colour_window_detector.sv
// colour_window_detector: tracks the VGA raster position and averages a
// WIN x WIN pixel window around a centre latched once per frame. It then
// issues per-channel averages and red/green/blue dominance flags.
module colour_window_detector #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int WIN_LOG2   = 3,
  parameter int CH_BITS    = 4,
  parameter int THRESH     = 3,
  parameter int MIN_BRIGHT = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3*CH_BITS-1:0] video_data,
  input  logic                 vga_ready,
  input  logic [9:0]           centre_x,
  input  logic [8:0]           centre_y,
  output logic [9:0]           x_count,
  output logic [8:0]           y_count,
  output logic [CH_BITS-1:0]   avg_red,
  output logic [CH_BITS-1:0]   avg_green,
  output logic [CH_BITS-1:0]   avg_blue,
  output logic                 result_valid,
  output logic                 red_detected,
  output logic                 green_detected,
  output logic                 blue_detected,
  output logic [7:0]           frame_count
);

  localparam int WIN   = 1 << WIN_LOG2;
  localparam int ACC_W = CH_BITS + 2*WIN_LOG2;
  localparam int DET_W = CH_BITS + 2;

  localparam logic [9:0]       X_LAST   = 10'(H_ACTIVE - 1);
  localparam logic [8:0]       Y_LAST   = 9'(V_ACTIVE - 1);
  localparam logic [9:0]       HALF     = 10'(WIN / 2);
  localparam logic [9:0]       WIN_M1   = 10'(WIN - 1);
  localparam logic [9:0]       X_LO_MAX = 10'(H_ACTIVE - WIN);
  localparam logic [9:0]       Y_LO_MAX = 10'(V_ACTIVE - WIN);
  localparam logic [DET_W-1:0] THRESH_D = DET_W'(THRESH);
  localparam logic [DET_W-1:0] MIN_D    = DET_W'(MIN_BRIGHT);

  typedef enum logic {ACCUM, RESULT} state_t;

  // Window start for one axis: centre minus half a window, kept inside the frame.
  function automatic logic [9:0] clamp_lo(input logic [9:0] c, input logic [9:0] lim);
    logic [9:0] lo;
    if (c < HALF) lo = '0;
    else          lo = c - HALF;
    if (lo > lim) lo = lim;
    return lo;
  endfunction

  // Channel a dominates b and c by more than THRESH and is bright enough.
  // Widened by two bits so that adding THRESH can never wrap.
  function automatic logic dominant(input logic [CH_BITS-1:0] a,
                                    input logic [CH_BITS-1:0] b,
                                    input logic [CH_BITS-1:0] c);
    logic [DET_W-1:0] ae, be, ce;
    ae = DET_W'(a);
    be = DET_W'(b) + THRESH_D;
    ce = DET_W'(c) + THRESH_D;
    return (ae > be) && (ae > ce) && (ae > MIN_D);
  endfunction

  logic [9:0]               x_q, x_d;
  logic [8:0]               y_q, y_d;
  logic [9:0]               cx_q, cx_d;
  logic [8:0]               cy_q, cy_d;
  state_t                   state_q, state_d;
  logic [ACC_W-1:0]         acc_r_q, acc_r_d, acc_g_q, acc_g_d, acc_b_q, acc_b_d;
  logic [CH_BITS-1:0]       avg_r_q, avg_r_d, avg_g_q, avg_g_d, avg_b_q, avg_b_d;
  logic                     det_r_q, det_r_d, det_g_q, det_g_d, det_b_q, det_b_d;
  logic                     rv_q, rv_d;
  logic [7:0]               fc_q, fc_d;
  logic                     win_vld_q, win_vld_d, win_last_q, win_last_d;
  logic [3*CH_BITS-1:0]     pix_q, pix_d;

  logic [9:0] x_lo, x_hi, y_lo, y_hi, y_ext;
  logic       frame_end, in_win;

  // Raster counter, centre latch at the last pixel of a frame, and window bounds.
  always_comb begin
    x_d       = x_q;
    y_d       = y_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    frame_end = vga_ready && (x_q == X_LAST) && (y_q == Y_LAST);
    x_lo      = clamp_lo(cx_q, X_LO_MAX);
    y_lo      = clamp_lo({1'b0, cy_q}, Y_LO_MAX);
    x_hi      = x_lo + WIN_M1;
    y_hi      = y_lo + WIN_M1;
    y_ext     = {1'b0, y_q};
    in_win    = vga_ready && (x_q >= x_lo) && (x_q <= x_hi) &&
                (y_ext >= y_lo) && (y_ext <= y_hi);
    if (vga_ready) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + 9'd1;
      end else begin
        x_d = x_q + 10'd1;
      end
    end
    if (frame_end) begin
      cx_d = centre_x;
      cy_d = centre_y;
    end
  end

  // Pixel stage: capture the accepted pixel with its in-window and last-pixel tags.
  always_comb begin
    pix_d      = video_data;
    win_vld_d  = in_win;
    win_last_d = in_win && (x_q == x_hi) && (y_ext == y_hi);
  end

  // Accumulate window pixels; the cycle after the last one, publish the result.
  always_comb begin
    state_d = state_q;
    acc_r_d = acc_r_q;
    acc_g_d = acc_g_q;
    acc_b_d = acc_b_q;
    avg_r_d = avg_r_q;
    avg_g_d = avg_g_q;
    avg_b_d = avg_b_q;
    det_r_d = det_r_q;
    det_g_d = det_g_q;
    det_b_d = det_b_q;
    rv_d    = 1'b0;
    fc_d    = fc_q;
    case (state_q)
      ACCUM: begin
        if (win_vld_q) begin
          acc_r_d = acc_r_q + ACC_W'(pix_q[3*CH_BITS-1 -: CH_BITS]);
          acc_g_d = acc_g_q + ACC_W'(pix_q[2*CH_BITS-1 -: CH_BITS]);
          acc_b_d = acc_b_q + ACC_W'(pix_q[CH_BITS-1:0]);
          if (win_last_q) state_d = RESULT;
        end
      end
      RESULT: begin
        // Top CH_BITS of the sum is the floor of sum / WIN^2.
        avg_r_d = acc_r_q[ACC_W-1 -: CH_BITS];
        avg_g_d = acc_g_q[ACC_W-1 -: CH_BITS];
        avg_b_d = acc_b_q[ACC_W-1 -: CH_BITS];
        det_r_d = dominant(avg_r_d, avg_g_d, avg_b_d);
        det_g_d = dominant(avg_g_d, avg_r_d, avg_b_d);
        det_b_d = dominant(avg_b_d, avg_r_d, avg_g_d);
        rv_d    = 1'b1;
        fc_d    = fc_q + 8'd1;
        // A window pixel arriving now belongs to the next window; start from it.
        acc_r_d = win_vld_q ? ACC_W'(pix_q[3*CH_BITS-1 -: CH_BITS]) : '0;
        acc_g_d = win_vld_q ? ACC_W'(pix_q[2*CH_BITS-1 -: CH_BITS]) : '0;
        acc_b_d = win_vld_q ? ACC_W'(pix_q[CH_BITS-1:0]) : '0;
        state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  // Control, accumulator and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q        <= '0;
      y_q        <= '0;
      cx_q       <= 10'(H_ACTIVE / 2);
      cy_q       <= 9'(V_ACTIVE / 2);
      state_q    <= ACCUM;
      acc_r_q    <= '0;
      acc_g_q    <= '0;
      acc_b_q    <= '0;
      avg_r_q    <= '0;
      avg_g_q    <= '0;
      avg_b_q    <= '0;
      det_r_q    <= 1'b0;
      det_g_q    <= 1'b0;
      det_b_q    <= 1'b0;
      rv_q       <= 1'b0;
      fc_q       <= '0;
      win_vld_q  <= 1'b0;
      win_last_q <= 1'b0;
    end else begin
      x_q        <= x_d;
      y_q        <= y_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      state_q    <= state_d;
      acc_r_q    <= acc_r_d;
      acc_g_q    <= acc_g_d;
      acc_b_q    <= acc_b_d;
      avg_r_q    <= avg_r_d;
      avg_g_q    <= avg_g_d;
      avg_b_q    <= avg_b_d;
      det_r_q    <= det_r_d;
      det_g_q    <= det_g_d;
      det_b_q    <= det_b_d;
      rv_q       <= rv_d;
      fc_q       <= fc_d;
      win_vld_q  <= win_vld_d;
      win_last_q <= win_last_d;
    end
  end

  // Pixel data register; only meaningful when win_vld_q is set.
  always_ff @(posedge clk) begin
    pix_q <= pix_d;
  end

  assign x_count        = x_q;
  assign y_count        = y_q;
  assign avg_red        = avg_r_q;
  assign avg_green      = avg_g_q;
  assign avg_blue       = avg_b_q;
  assign result_valid   = rv_q;
  assign red_detected   = det_r_q;
  assign green_detected = det_g_q;
  assign blue_detected  = det_b_q;
  assign frame_count    = fc_q;

endmodule

// File: tb/tb_colour_window_detector.sv
// Bench for colour_window_detector on a reduced 24x16 raster with an 8x8 window.
// A reference model computes window averages and flags straight from the frame image.
module tb_colour_window_detector;

  localparam int H   = 24;
  localparam int V   = 16;
  localparam int WL  = 3;
  localparam int CB  = 4;
  localparam int TH  = 3;
  localparam int MB  = 6;
  localparam int WIN = 1 << WL;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] video_data = '0;
  logic        vga_ready = 1'b0;
  logic [9:0]  centre_x = 10'(H/2);
  logic [8:0]  centre_y = 9'(V/2);
  logic [9:0]  x_count;
  logic [8:0]  y_count;
  logic [3:0]  avg_red, avg_green, avg_blue;
  logic        result_valid, red_detected, green_detected, blue_detected;
  logic [7:0]  frame_count;

  colour_window_detector #(
    .H_ACTIVE(H), .V_ACTIVE(V), .WIN_LOG2(WL), .CH_BITS(CB),
    .THRESH(TH), .MIN_BRIGHT(MB)
  ) dut (
    .clk(clk), .reset(reset), .video_data(video_data), .vga_ready(vga_ready),
    .centre_x(centre_x), .centre_y(centre_y), .x_count(x_count), .y_count(y_count),
    .avg_red(avg_red), .avg_green(avg_green), .avg_blue(avg_blue),
    .result_valid(result_valid), .red_detected(red_detected),
    .green_detected(green_detected), .blue_detected(blue_detected),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int edge_no;
    int r, g, b;
    int rd, gd, bd;
    int fc;
  } res_t;

  res_t        exp_q[$];
  res_t        cur;
  logic [11:0] img [V][H];
  int          total = 0;
  int          bad = 0;
  int          edge_n = 0;
  int          m_x = 0, m_y = 0;
  int          m_cx = H/2, m_cy = V/2;
  int          exp_fc = 0;
  bit          mon_en = 1'b0;
  bit          pulse;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int win_lo(input int c, input int size);
    int lo;
    lo = c - WIN/2;
    if (lo < 0) lo = 0;
    if (lo > size - WIN) lo = size - WIN;
    return lo;
  endfunction

  function automatic res_t window_avg(input int xlo, input int ylo);
    res_t r;
    int sr, sg, sb;
    sr = 0; sg = 0; sb = 0;
    for (int dy = 0; dy < WIN; dy++)
      for (int dx = 0; dx < WIN; dx++) begin
        sr += int'(img[ylo+dy][xlo+dx][11:8]);
        sg += int'(img[ylo+dy][xlo+dx][7:4]);
        sb += int'(img[ylo+dy][xlo+dx][3:0]);
      end
    r.r = sr / (WIN*WIN);
    r.g = sg / (WIN*WIN);
    r.b = sb / (WIN*WIN);
    r.rd = (r.r > r.g + TH && r.r > r.b + TH && r.r > MB) ? 1 : 0;
    r.gd = (r.g > r.r + TH && r.g > r.b + TH && r.g > MB) ? 1 : 0;
    r.bd = (r.b > r.r + TH && r.b > r.g + TH && r.b > MB) ? 1 : 0;
    r.fc = 0;
    r.edge_no = 0;
    return r;
  endfunction

  // Model bookkeeping for the pixel accepted at the most recent edge.
  task automatic accepted();
    int xlo, ylo;
    res_t r;
    xlo = win_lo(m_cx, H);
    ylo = win_lo(m_cy, V);
    if (m_x == xlo + WIN - 1 && m_y == ylo + WIN - 1) begin
      r = window_avg(xlo, ylo);
      exp_fc = (exp_fc + 1) % 256;
      r.fc = exp_fc;
      r.edge_no = edge_n + 2;
      exp_q.push_back(r);
    end
    if (m_x == H-1 && m_y == V-1) begin
      m_cx = int'(centre_x);
      m_cy = int'(centre_y);
    end
    m_x++;
    if (m_x == H) begin
      m_x = 0;
      m_y++;
      if (m_y == V) m_y = 0;
    end
  endtask

  // Stream n pixels from the image at the model position, optionally with stalls.
  task automatic stream(input int n, input int gap);
    int s;
    for (int i = 0; i < n; i++) begin
      s = 0;
      while (s < 5 && $urandom_range(99) < gap) begin
        vga_ready = 1'b0;
        video_data = 12'($urandom);
        @(posedge clk); #1;
        s++;
      end
      vga_ready = 1'b1;
      video_data = img[m_y][m_x];
      @(posedge clk); #1;
      vga_ready = 1'b0;
      accepted();
    end
  endtask

  task automatic fill_uniform(input logic [11:0] v);
    for (int y = 0; y < V; y++) for (int x = 0; x < H; x++) img[y][x] = v;
  endtask

  task automatic fill_checker();
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++) img[y][x] = ((x + y) % 2 == 1) ? 12'hFFF : 12'h000;
  endtask

  task automatic fill_block(input int x0, input int y0, input logic [11:0] v);
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++)
        img[y][x] = (x >= x0 && x < x0 + WIN && y >= y0 && y < y0 + WIN) ? v : 12'h000;
  endtask

  task automatic fill_random();
    for (int y = 0; y < V; y++) for (int x = 0; x < H; x++) img[y][x] = 12'($urandom);
  endtask

  // Output monitor: pulse timing, held results and raster position every cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      pulse = 1'b0;
      while (exp_q.size() > 0 && exp_q[0].edge_no < edge_n) void'(exp_q.pop_front());
      if (exp_q.size() > 0 && exp_q[0].edge_no == edge_n) begin
        cur = exp_q.pop_front();
        pulse = 1'b1;
      end
      chk("result_valid", result_valid, pulse);
      chk("avg_red", avg_red, cur.r);
      chk("avg_green", avg_green, cur.g);
      chk("avg_blue", avg_blue, cur.b);
      chk("red_detected", red_detected, cur.rd);
      chk("green_detected", green_detected, cur.gd);
      chk("blue_detected", blue_detected, cur.bd);
      chk("frame_count", frame_count, cur.fc);
      chk("x_count", x_count, m_x);
      chk("y_count", y_count, m_y);
    end
  end

  task automatic check_reset_outputs(input string pfx);
    chk({pfx, "_x"}, x_count, 0);
    chk({pfx, "_y"}, y_count, 0);
    chk({pfx, "_avg_r"}, avg_red, 0);
    chk({pfx, "_avg_g"}, avg_green, 0);
    chk({pfx, "_avg_b"}, avg_blue, 0);
    chk({pfx, "_rv"}, result_valid, 0);
    chk({pfx, "_flags"}, {red_detected, green_detected, blue_detected}, 0);
    chk({pfx, "_fc"}, frame_count, 0);
  endtask

  task automatic model_reset();
    exp_q.delete();
    cur = '{default: 0};
    exp_fc = 0;
    m_x = 0; m_y = 0;
    m_cx = H/2; m_cy = V/2;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    cur = '{default: 0};
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 1'b0;
    mon_en = 1'b1;

    // Uniform red frames at the default centre.
    fill_uniform(12'hF00);
    repeat (3) stream(H*V, 0);

    // Checkerboard window; new centre requested mid-frame applies next frame.
    centre_x = 10'd0; centre_y = 9'd0;
    fill_checker();
    stream(H*V, 0);

    // Window clamped at the top-left corner; far corner requested halfway through.
    fill_block(0, 0, 12'h0A0);
    stream(H*V/2, 0);
    centre_x = 10'd639; centre_y = 9'd479;
    stream(H*V/2, 0);

    // Window clamped at the bottom-right corner.
    fill_block(H - WIN, V - WIN, 12'h00B);
    centre_x = 10'(H/2); centre_y = 9'(V/2);
    stream(H*V, 0);

    // Detection margins near the top of the channel range.
    fill_uniform(12'hF0D);
    stream(H*V, 0);
    fill_uniform(12'hEA0);
    stream(H*V, 0);

    // Random images and centres, each replayed gap-free and with stalls.
    repeat (3) begin
      centre_x = 10'($urandom_range(H + 4));
      centre_y = 9'($urandom_range(V + 4));
      fill_random();
      stream(H*V, 0);
      stream(H*V, 0);
      stream(H*V, 30);
    end

    // Reset in the middle of the window discards the partial sum.
    centre_x = 10'(H/2); centre_y = 9'(V/2);
    fill_random();
    stream(H*V, 30);
    fill_uniform(12'h0F0);
    stream(6*H + 10, 30);
    #2;
    mon_en = 1'b0;
    reset = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk); #1;
    model_reset();
    reset = 1'b0;
    mon_en = 1'b1;

    fill_uniform(12'hF00);
    stream(H*V, 0);

    repeat (4) @(posedge clk);
    #1;
    chk("pending_results", exp_q.size(), 0);
    chk("final_frame_count", frame_count, 1);
    chk("final_red", red_detected, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
